pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural PC register and decides the next PC each cycle.
- Arbitrates between next-PC sources in fixed priority: sequential (PC+4), jump, branch, and optionally trap.
- Handles stall, halt and instruction-memory backpressure.
- Sits between the decode/execute redirect logic and the instruction-fetch port. It drives the fetch address with a valid/ready handshake.

Parameters:
- PC_LEN, 32, width of PC and all target buses
- RESET_VEC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, trap handler address (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  leave IDLE and begin fetching
- halt_req  input  1  stop fetching after the current handshake
- stall  input  1  hold PC (pipeline hazard)
- jmp_valid  input  1  unconditional jump request
- jmp_target  input  PC_LEN  jump target
- br_taken  input  1  taken branch resolved this cycle
- br_target  input  PC_LEN  branch target
- imem_req  output  1  fetch request valid
- imem_addr  output  PC_LEN  fetch address (equals pc_out)
- imem_ready  input  1  memory accepts request this cycle
- pc_out  output  PC_LEN  current PC
- pc_plus4  output  PC_LEN  pc_out + 4, combinational, modulo 2^PC_LEN
- redirect  output  1  one-cycle pulse when PC is loaded from a non-sequential source (flushes younger stages)
- halted  output  1  high in HALTED

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-handshake):
  - pc_out=RESET_VEC, state=IDLE, imem_req=0, redirect=0, halted=0, pending redirect cleared.
- States:
  - IDLE: imem_req=0. On start=1, go to RUN next cycle.
  - RUN: imem_req=1 unless stall=1.
    - imem_req&imem_ready: handshake; PC updates at that edge.
    - imem_req&!imem_ready: go to WAIT_MEM.
  - WAIT_MEM: imem_req=1; imem_addr held stable. On imem_ready, go to RUN and update PC.
  - HALTED: imem_req=0, halted=1. start=1 returns to RUN with PC unchanged. Redirects in HALTED are ignored.
- Next-PC priority: trap (if enabled) > br_taken > jmp_valid > pc_plus4.
- Redirect inputs are single-cycle pulses.
- Redirect in RUN:
  - Applied on the next edge regardless of imem_ready; the in-flight address is abandoned.
  - Takes effect even with stall=1, because a redirect overrides stall.
  - redirect=1 for the cycle after the load.
- Redirect in WAIT_MEM:
  - Target is latched into a pending register; imem_addr is not changed.
  - On the completing handshake, PC loads the pending target instead of PC+4, and redirect pulses.
  - A later, higher-priority redirect overwrites the pending one. Equal or lower priority does not overwrite.
- Sequential advance only on a handshake with no redirect, stall or pending target.
- stall=1 in RUN with no redirect: PC held, imem_req=0.
- halt_req:
  - In RUN: go to HALTED next cycle.
  - In WAIT_MEM: wait for imem_ready, complete the update, then go to HALTED.
- Targets: bits [1:0] forced to 0 on load. PC is always word aligned.
- Wrap-around: PC at {PC_LEN{1'b1}} & ~3 advances to 0. No error is raised.
- Simultaneous start and halt_req in IDLE: halt wins; go to HALTED.

Optional Feature:
- Macro: PC_SEQ_TRAP_EN.
- Defined:
  - Adds input trap_req (1) and output epc (PC_LEN).
  - trap_req has highest priority and loads TRAP_VEC.
  - epc captures the pc_out of the trapping cycle; epc resets to 0.
  - Also honoured in WAIT_MEM through the pending register.
- Undefined: no trap port and no epc; the priority chain starts at br_taken.

Decomposition:
- Package pc_seq_pkg:
  - state enum pc_state_t {IDLE, RUN, WAIT_MEM, HALTED}
  - next-PC source enum pc_src_t {SRC_SEQ, SRC_JMP, SRC_BR, SRC_TRAP} with priority encoded in value
  - default vector constants
- Sub-module pc_next_sel: combinational priority mux plus alignment. It takes the source valids and targets and returns the chosen target and pc_src_t.
- The +4 adder is instantiated from the existing pc incrementer block.

Test Plan:
- Reset, then start with imem_ready=1 for 4 cycles -> imem_addr 0x0,0x4,0x8,0xC; redirect=0.
- At PC=0x8: br_taken=1, br_target=0x203 in the same cycle as jmp_valid=1, jmp_target=0x40 -> next PC=0x200; redirect pulses 1 cycle.
- At PC=0x10: imem_ready=0 for 3 cycles with jmp_valid pulse (0x80) in the 2nd wait cycle -> imem_addr stays 0x10 until ready; then PC=0x80; redirect=1.
- stall=1 for 2 cycles at PC=0x14 -> imem_req=0 and PC held. Repeat with br_taken (0x300) during stall -> PC=0x300.
- Load PC=0xFFFFFFFC via jump, handshake -> PC=0x00000000.
- rst asserted mid-WAIT_MEM -> same-cycle imem_req=0, pc_out=RESET_VEC, state IDLE. With PC_SEQ_TRAP_EN: trap_req at PC=0x24 -> PC=0x100, epc=0x24.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared states, next-PC source ranks and default vectors for pc_sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, WAIT_MEM, HALTED} pc_state_t;
  // Encoded value doubles as priority rank: larger value wins.
  typedef enum logic [1:0] {SRC_SEQ, SRC_JMP, SRC_BR, SRC_TRAP} pc_src_t;
  localparam int DEF_PC_LEN = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
endpackage

// File: rtl/pc_incr.sv
// pc_incr: PC incrementer, adds 4 modulo 2^W.
module pc_incr #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = a + W'(4);
endmodule

// File: rtl/pc_next_sel.sv
// pc_next_sel: fixed-priority next-PC mux (trap > branch > jump > sequential) with word alignment.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int PC_LEN = DEF_PC_LEN
) (
  input  logic              trap_valid,
  input  logic [PC_LEN-1:0] trap_target,
  input  logic              br_valid,
  input  logic [PC_LEN-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [PC_LEN-1:0] jmp_target,
  input  logic [PC_LEN-1:0] seq_target,
  output logic [PC_LEN-1:0] target,
  output pc_src_t           src
);
  logic [PC_LEN-1:0] raw;
  assign src = trap_valid ? SRC_TRAP : br_valid ? SRC_BR : jmp_valid ? SRC_JMP : SRC_SEQ;
  assign raw = trap_valid ? trap_target : br_valid ? br_target : jmp_valid ? jmp_target : seq_target;
  assign target = {raw[PC_LEN-1:2], 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC owner driving the fetch handshake with redirect, stall and halt.
// Define PC_SEQ_TRAP_EN to add the trap_req input and epc output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                PC_LEN    = DEF_PC_LEN,
  parameter logic [PC_LEN-1:0] RESET_VEC = PC_LEN'(DEF_RESET_VEC),
  parameter logic [PC_LEN-1:0] TRAP_VEC  = PC_LEN'(DEF_TRAP_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              jmp_valid,
  input  logic [PC_LEN-1:0] jmp_target,
  input  logic              br_taken,
  input  logic [PC_LEN-1:0] br_target,
`ifdef PC_SEQ_TRAP_EN
  input  logic              trap_req,
  output logic [PC_LEN-1:0] epc,
`endif
  output logic              imem_req,
  output logic [PC_LEN-1:0] imem_addr,
  input  logic              imem_ready,
  output logic [PC_LEN-1:0] pc_out,
  output logic [PC_LEN-1:0] pc_plus4,
  output logic              redirect,
  output logic              halted
);
  pc_state_t state, state_d;
  pc_src_t in_src, pend_src, pend_src_d, eff_src;
  logic [PC_LEN-1:0] pc, pc_d, in_tgt, pend_tgt, pend_tgt_d, eff_tgt;
  logic halt_pend, halt_pend_d, redirect_d, trap_valid, in_wins;

`ifdef PC_SEQ_TRAP_EN
  assign trap_valid = trap_req;
  always_ff @(posedge clk or posedge rst)
    if (rst) epc <= '0;
    else if (in_src == SRC_TRAP && (state == RUN || state == WAIT_MEM)) epc <= pc;
`else
  assign trap_valid = 1'b0;
`endif

  pc_incr #(.W(PC_LEN)) u_incr (.a(pc), .y(pc_plus4));

  pc_next_sel #(.PC_LEN(PC_LEN)) u_sel (
    .trap_valid (trap_valid),
    .trap_target(TRAP_VEC),
    .br_valid   (br_taken),
    .br_target  (br_target),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .seq_target (pc_plus4),
    .target     (in_tgt),
    .src        (in_src)
  );

  // A parked redirect is only displaced by a strictly higher-ranked newcomer.
  assign in_wins = in_src > pend_src;
  assign eff_src = in_wins ? in_src : pend_src;
  assign eff_tgt = in_wins ? in_tgt : pend_tgt;

  assign imem_req = (state == RUN && !stall) || state == WAIT_MEM;
  assign imem_addr = pc;
  assign pc_out = pc;
  assign halted = state == HALTED;

  always_comb begin
    state_d = state;
    pc_d = pc;
    pend_src_d = pend_src;
    pend_tgt_d = pend_tgt;
    halt_pend_d = halt_pend;
    redirect_d = 1'b0;
    case (state)
      IDLE: state_d = halt_req ? HALTED : start ? RUN : IDLE;
      RUN: begin
        redirect_d = in_src != SRC_SEQ;
        pc_d = redirect_d ? in_tgt : (!stall && imem_ready) ? pc_plus4 : pc;
        state_d = halt_req ? HALTED : (!redirect_d && !stall && !imem_ready) ? WAIT_MEM : RUN;
      end
      WAIT_MEM: begin
        redirect_d = imem_ready && eff_src != SRC_SEQ;
        pc_d = !imem_ready ? pc : redirect_d ? eff_tgt : pc_plus4;
        pend_src_d = imem_ready ? SRC_SEQ : eff_src;
        pend_tgt_d = eff_tgt;
        halt_pend_d = !imem_ready && (halt_pend || halt_req);
        state_d = !imem_ready ? WAIT_MEM : (halt_pend || halt_req) ? HALTED : RUN;
      end
      HALTED: state_d = start ? RUN : HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= RESET_VEC;
      pend_src <= SRC_SEQ;
      pend_tgt <= '0;
      halt_pend <= 1'b0;
      redirect <= 1'b0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      pend_src <= pend_src_d;
      pend_tgt <= pend_tgt_d;
      halt_pend <= halt_pend_d;
      redirect <= redirect_d;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst, start, halt_req, stall, jmp_valid, br_taken, imem_ready, imem_req, redirect, halted;
  logic [31:0] jmp_target, br_target, imem_addr, pc_out, pc_plus4;
`ifdef PC_SEQ_TRAP_EN
  logic trap_req;
  logic [31:0] epc;
`endif
  int compared = 0;
  int mismatched = 0;

  // model: mode 0 idle, 1 run, 2 waiting on memory, 3 halted; rank 0 none, 1 jump, 2 branch, 3 trap
  logic [31:0] m_pc, m_pend_tgt, m_epc;
  int m_mode, m_pend_rank;
  bit m_halt_pend, m_redir;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target), .br_taken(br_taken), .br_target(br_target),
`ifdef PC_SEQ_TRAP_EN
    .trap_req(trap_req), .epc(epc),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .redirect(redirect), .halted(halted)
  );

  function automatic int in_rank();
`ifdef PC_SEQ_TRAP_EN
    if (trap_req) return 3;
`endif
    return br_taken ? 2 : jmp_valid ? 1 : 0;
  endfunction

  function automatic logic [31:0] in_tgt();
`ifdef PC_SEQ_TRAP_EN
    if (trap_req) return 32'h100;
`endif
    return (br_taken ? br_target : jmp_target) & 32'hFFFF_FFFC;
  endfunction

  function automatic logic exp_req();
    return (m_mode == 1 && !stall) || m_mode == 2;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_mode = 0; m_pend_rank = 0; m_pend_tgt = 0;
    m_halt_pend = 0; m_redir = 0; m_epc = 0;
  endtask

  task automatic clear_pulses();
    start = 0; halt_req = 0; jmp_valid = 0; br_taken = 0;
`ifdef PC_SEQ_TRAP_EN
    trap_req = 0;
`endif
  endtask

  // One clock: the model advances from the current inputs, then single-cycle requests drop.
  task automatic tick();
    int r, nmode;
    logic [31:0] t, npc;
    bit nred;
    r = in_rank(); t = in_tgt(); npc = m_pc; nmode = m_mode; nred = 0;
    case (m_mode)
      0: nmode = halt_req ? 3 : start ? 1 : 0;
      1: begin
        if (r > 0) begin npc = t; nred = 1; if (r == 3) m_epc = m_pc; end
        else if (!stall && imem_ready) npc = m_pc + 32'd4;
        nmode = halt_req ? 3 : (r == 0 && !stall && !imem_ready) ? 2 : 1;
      end
      2: begin
        if (r > m_pend_rank) begin m_pend_rank = r; m_pend_tgt = t; end
        if (r == 3) m_epc = m_pc;
        m_halt_pend = m_halt_pend | halt_req;
        if (imem_ready) begin
          npc = m_pend_rank > 0 ? m_pend_tgt : m_pc + 32'd4;
          nred = m_pend_rank > 0;
          nmode = m_halt_pend ? 3 : 1;
          m_pend_rank = 0; m_halt_pend = 0;
        end
      end
      default: nmode = start ? 1 : 3;
    endcase
    @(posedge clk);
    m_pc = npc; m_mode = nmode; m_redir = nred;
    #1;
    clear_pulses();
  endtask

  task automatic test_reset();
    rst = 1; clear_pulses(); stall = 0; imem_ready = 0; jmp_target = 0; br_target = 0;
    m_reset();
    #2;
    compared++; if (pc_out !== 32'h0) begin mismatched++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
    compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req got %b want 0", imem_req); end
    compared++; if (redirect !== 1'b0) begin mismatched++; $display("FAIL reset_redirect got %b want 0", redirect); end
    compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted got %b want 0", halted); end
    compared++; if (pc_plus4 !== 32'h4) begin mismatched++; $display("FAIL reset_plus4 got %h want %h", pc_plus4, 32'h4); end
    rst = 0;
  endtask

  task automatic test_sequential();
    start = 1; imem_ready = 1; #1;
    compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL idle_req got %b want 0", imem_req); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++; if (imem_addr !== 32'(i * 4)) begin mismatched++; $display("FAIL seq_addr%0d got %h want %h", i, imem_addr, 32'(i * 4)); end
      compared++; if (imem_req !== 1'b1 || redirect !== 1'b0) begin mismatched++; $display("FAIL seq_ctl%0d got req=%b redir=%b want req=1 redir=0", i, imem_req, redirect); end
      tick();
    end
  endtask

  task automatic test_branch_priority();
    br_taken = 1; br_target = 32'h203; jmp_valid = 1; jmp_target = 32'h40;
    tick();
    compared++; if (pc_out !== 32'h200) begin mismatched++; $display("FAIL br_prio_pc got %h want %h", pc_out, 32'h200); end
    compared++; if (redirect !== 1'b1) begin mismatched++; $display("FAIL br_prio_redirect got %b want 1", redirect); end
    tick();
    compared++; if (pc_out !== 32'h204 || redirect !== 1'b0) begin mismatched++; $display("FAIL br_after got pc=%h redir=%b want pc=204 redir=0", pc_out, redirect); end
  endtask

  task automatic test_wait_redirect();
    int kind [3][2] = '{'{1, 0}, '{2, 1}, '{1, 2}};
    logic [31:0] tg [3][2] = '{'{32'h80, 32'h0}, '{32'h300, 32'h500}, '{32'h500, 32'h606}};
    logic [31:0] want [3] = '{32'h80, 32'h300, 32'h604};
    logic [31:0] hold;
    for (int e = 0; e < 3; e++) begin
      hold = m_pc;
      imem_ready = 0;
      tick();
      for (int c = 0; c < 2; c++) begin
        jmp_valid = kind[e][c] == 1; jmp_target = tg[e][c];
        br_taken = kind[e][c] == 2; br_target = tg[e][c];
        tick();
        compared++; if (imem_addr !== hold || imem_req !== 1'b1 || redirect !== 1'b0) begin
          mismatched++; $display("FAIL wait_hold%0d_%0d got addr=%h req=%b redir=%b want addr=%h req=1 redir=0", e, c, imem_addr, imem_req, redirect, hold);
        end
      end
      imem_ready = 1;
      tick();
      compared++; if (pc_out !== want[e] || redirect !== 1'b1) begin
        mismatched++; $display("FAIL wait_load%0d got pc=%h redir=%b want pc=%h redir=1", e, pc_out, redirect, want[e]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] hold;
    hold = m_pc; stall = 1; imem_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL stall_req%0d got %b want 0", i, imem_req); end
      tick();
      compared++; if (pc_out !== hold) begin mismatched++; $display("FAIL stall_hold%0d got %h want %h", i, pc_out, hold); end
    end
    br_taken = 1; br_target = 32'h300;
    tick();
    compared++; if (pc_out !== 32'h300 || redirect !== 1'b1) begin mismatched++; $display("FAIL stall_br got pc=%h redir=%b want pc=300 redir=1", pc_out, redirect); end
    stall = 0;
  endtask

  task automatic test_wrap();
    jmp_valid = 1; jmp_target = 32'hFFFF_FFFF;
    tick();
    compared++; if (pc_out !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_align got %h want %h", pc_out, 32'hFFFF_FFFC); end
    compared++; if (pc_plus4 !== 32'h0) begin mismatched++; $display("FAIL wrap_plus4 got %h want 0", pc_plus4); end
    tick();
    compared++; if (pc_out !== 32'h0) begin mismatched++; $display("FAIL wrap_pc got %h want 0", pc_out); end
  endtask

  task automatic test_halt();
    halt_req = 1;
    tick();
    compared++; if (halted !== 1'b1 || pc_out !== 32'h4 || imem_req !== 1'b0) begin
      mismatched++; $display("FAIL halt_run got halted=%b pc=%h req=%b want 1 4 0", halted, pc_out, imem_req);
    end
    br_taken = 1; br_target = 32'h900;
    tick();
    compared++; if (pc_out !== 32'h4 || redirect !== 1'b0) begin mismatched++; $display("FAIL halt_ignore got pc=%h redir=%b want 4 0", pc_out, redirect); end
    start = 1;
    tick();
    compared++; if (halted !== 1'b0 || pc_out !== 32'h4 || imem_req !== 1'b1) begin
      mismatched++; $display("FAIL halt_resume got halted=%b pc=%h req=%b want 0 4 1", halted, pc_out, imem_req);
    end
    imem_ready = 0;
    tick();
    halt_req = 1;
    tick();
    compared++; if (halted !== 1'b0 || pc_out !== 32'h4) begin mismatched++; $display("FAIL halt_wait_early got halted=%b pc=%h want 0 4", halted, pc_out); end
    imem_ready = 1;
    tick();
    compared++; if (halted !== 1'b1 || pc_out !== 32'h8) begin mismatched++; $display("FAIL halt_wait_done got halted=%b pc=%h want 1 8", halted, pc_out); end
    start = 1;
    tick();
  endtask

  task automatic test_async_reset();
    imem_ready = 0;
    tick();
    #3 rst = 1;
    m_reset();
    #1;
    compared++; if (imem_req !== 1'b0 || pc_out !== 32'h0 || halted !== 1'b0 || redirect !== 1'b0) begin
      mismatched++; $display("FAIL async_rst got req=%b pc=%h halted=%b redir=%b want 0 0 0 0", imem_req, pc_out, halted, redirect);
    end
    #1 rst = 0;
    imem_ready = 1;
    tick();
    compared++; if (imem_req !== 1'b0 || pc_out !== 32'h0) begin mismatched++; $display("FAIL rst_idle got req=%b pc=%h want 0 0", imem_req, pc_out); end
    start = 1; halt_req = 1;
    tick();
    compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL idle_halt_wins got %b want 1", halted); end
    start = 1;
    tick();
  endtask

`ifdef PC_SEQ_TRAP_EN
  task automatic test_trap();
    jmp_valid = 1; jmp_target = 32'h24; imem_ready = 1; stall = 0;
    tick();
    trap_req = 1; br_taken = 1; br_target = 32'h500;
    tick();
    compared++; if (pc_out !== 32'h100 || epc !== 32'h24 || redirect !== 1'b1) begin
      mismatched++; $display("FAIL trap got pc=%h epc=%h redir=%b want 100 24 1", pc_out, epc, redirect);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      start = $urandom_range(0, 3) == 0;
      halt_req = $urandom_range(0, 15) == 0;
      stall = $urandom_range(0, 3) == 0;
      imem_ready = $urandom_range(0, 2) != 0;
      jmp_valid = $urandom_range(0, 5) == 0;
      br_taken = $urandom_range(0, 5) == 0;
      jmp_target = $urandom;
      br_target = $urandom;
`ifdef PC_SEQ_TRAP_EN
      trap_req = $urandom_range(0, 19) == 0;
`endif
      #1;
      compared++; if (imem_req !== exp_req() || imem_addr !== m_pc) begin
        mismatched++; $display("FAIL rnd_fetch%0d got req=%b addr=%h want req=%b addr=%h", n, imem_req, imem_addr, exp_req(), m_pc);
      end
      tick();
      compared++; if (pc_out !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        mismatched++; $display("FAIL rnd_pc%0d got pc=%h plus4=%h want pc=%h", n, pc_out, pc_plus4, m_pc);
      end
      compared++; if (redirect !== m_redir || halted !== (m_mode == 3)) begin
        mismatched++; $display("FAIL rnd_flags%0d got redir=%b halted=%b want redir=%b halted=%b", n, redirect, halted, m_redir, m_mode == 3);
      end
`ifdef PC_SEQ_TRAP_EN
      compared++; if (epc !== m_epc) begin mismatched++; $display("FAIL rnd_epc%0d got %h want %h", n, epc, m_epc); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_priority();
    test_wait_redirect();
    test_stall();
    test_wrap();
    test_halt();
    test_async_reset();
`ifdef PC_SEQ_TRAP_EN
    test_trap();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
